// File: rtl/seg7_capture.sv
// seg7_capture
//   Watches a multiplexed, active-low seven-segment display bus. A {seg,an}
//   sample that stays identical for STABLE_CYCLES consecutive samples is
//   decoded once into the per-digit register file.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   seg[6:0]     active-low segments {g,f,e,d,c,b,a}
//   an[3:0]      active-low digit select (one-hot-low)
//   digit_val    captured hex value per digit, nibble i = digit i
//   digit_blank  bit i set when digit i last captured the blank pattern
//   cap_valid    one-cycle pulse per capture event
//   cap_idx      digit index of the capture (0 when idle)
//   cap_val      decoded value of the capture (0 when idle or illegal)
//   cap_err      capture of an illegal segment pattern
//   sel_err      level, high while the sampled an is not one-hot-low
module seg7_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digit_val,
    output logic [3:0]  digit_blank,
    output logic        cap_valid,
    output logic [1:0]  cap_idx,
    output logic [3:0]  cap_val,
    output logic        cap_err,
    output logic        sel_err
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {ST_WAIT, ST_COUNT, ST_LOCKED} state_t;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] cnt_inc;
    logic       capture;

    // Sample stage plus one older sample; every decision looks only at these.
    logic [6:0] samp_seg, prev_seg;
    logic [3:0] samp_an, prev_an;

    logic       sel_ok;
    logic [1:0] sel_idx;
    logic       same;
    logic [3:0] dec_val;
    logic       dec_legal;
    logic       is_blank;

    always_comb begin
        sel_ok  = 1'b1;
        sel_idx = 2'd0;
        case (samp_an)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_ok  = 1'b0;
        endcase
    end

    always_comb begin
        dec_legal = 1'b1;
        dec_val   = 4'h0;
        case (samp_seg)
            7'b1000000: dec_val = 4'h0;
            7'b1111001: dec_val = 4'h1;
            7'b0100100: dec_val = 4'h2;
            7'b0110000: dec_val = 4'h3;
            7'b0011001: dec_val = 4'h4;
            7'b0010010: dec_val = 4'h5;
            7'b0000010: dec_val = 4'h6;
            7'b1111000: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0010000: dec_val = 4'h9;
            7'b0001000: dec_val = 4'hA;
            7'b0000011: dec_val = 4'hB;
            7'b1000110: dec_val = 4'hC;
            7'b0100001: dec_val = 4'hD;
            7'b0000110: dec_val = 4'hE;
            7'b0001110: dec_val = 4'hF;
            default:    dec_legal = 1'b0;
        endcase
    end

    assign is_blank = (samp_seg == 7'b1111111);
    assign same     = ({samp_seg, samp_an} == {prev_seg, prev_an});
    assign cnt_inc  = cnt + 8'd1;

    // A bad select overrides every state. A capture fires on the same edge
    // the counter reaches STABLE, so a differing sample on that edge simply
    // restarts the count instead.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        if (!sel_ok) begin
            state_n = ST_WAIT;
            cnt_n   = 8'd0;
        end else begin
            case (state)
                ST_WAIT: begin
                    state_n = ST_COUNT;
                    cnt_n   = 8'd1;
                end
                ST_COUNT: begin
                    if (same) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == STABLE) begin
                            state_n = ST_LOCKED;
                            capture = 1'b1;
                        end
                    end else begin
                        cnt_n = 8'd1;
                    end
                end
                ST_LOCKED: begin
                    if (!same) begin
                        state_n = ST_COUNT;
                        cnt_n   = 8'd1;
                    end
                end
                default: begin
                    state_n = ST_WAIT;
                    cnt_n   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_WAIT;
            cnt         <= 8'd0;
            samp_seg    <= 7'b1111111;
            samp_an     <= 4'b1111;
            prev_seg    <= 7'b1111111;
            prev_an     <= 4'b1111;
            digit_val   <= 16'h0000;
            digit_blank <= 4'b1111;
            cap_valid   <= 1'b0;
            cap_err     <= 1'b0;
            cap_idx     <= 2'd0;
            cap_val     <= 4'd0;
            sel_err     <= 1'b1;
        end else begin
            samp_seg  <= seg;
            samp_an   <= an;
            prev_seg  <= samp_seg;
            prev_an   <= samp_an;
            state     <= state_n;
            cnt       <= cnt_n;
            sel_err   <= !sel_ok;
            cap_valid <= capture;
            cap_err   <= capture && !dec_legal && !is_blank;
            cap_idx   <= capture ? sel_idx : 2'd0;
            cap_val   <= (capture && dec_legal) ? dec_val : 4'd0;
            // Illegal patterns leave the register file untouched.
            if (capture && dec_legal) begin
                digit_val[{sel_idx, 2'b00} +: 4] <= dec_val;
                digit_blank[sel_idx]             <= 1'b0;
            end else if (capture && is_blank) begin
                digit_val[{sel_idx, 2'b00} +: 4] <= 4'h0;
                digit_blank[sel_idx]             <= 1'b1;
            end
        end
    end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive identical samples required before a capture (legal range 2..255).
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port seg  input  7  active-low segment bus, bit order {g,f,e,d,c,b,a}.
REQ-005 SHALL have port an  input  4  active-low digit select; exactly one low bit selects digit 0..3.
REQ-006 SHALL have port digit_val  output  16  captured hex values, nibble i (bits 4i+3:4i) holds digit i.
REQ-007 SHALL have port digit_blank  output  4  bit i high when digit i last captured the blank pattern.
REQ-008 SHALL have port cap_valid  output  1  one-cycle pulse per capture event.
REQ-009 SHALL have port cap_idx  output  2  digit index of the current capture, valid with cap_valid.
REQ-010 SHALL have port cap_val  output  4  decoded value of the current capture, valid with cap_valid.
REQ-011 SHALL have port cap_err  output  1  high with cap_valid when the captured pattern is illegal.
REQ-012 SHALL have port sel_err  output  1  registered level, high while the sampled an is not one-hot-low.

Function
REQ-013 SHALL register seg and an every cycle into a sample stage; all decisions use sampled values only.
REQ-014 SHALL decode active-low patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-015 SHALL treat 1111111 as blank: capture sets digit_blank[i]=1, nibble i=0, cap_val=0, cap_err=0.
REQ-016 SHALL treat any other pattern as illegal: cap_valid=1, cap_err=1, cap_val=0; digit_val and digit_blank unchanged.
REQ-017 SHALL implement states WAIT, COUNT, LOCKED with an 8-bit stability counter.
REQ-018 WAIT: entered whenever the sampled an is not one-hot-low; sel_err=1; counter=0; no capture.
REQ-019 WAIT->COUNT when the sampled an becomes one-hot-low; counter=1 for that sample.
REQ-020 COUNT: counter increments on each sample equal to the previous sample ({seg,an} both); any difference restarts the counter at 1 and stays in COUNT.
REQ-021 COUNT->LOCKED when the counter reaches STABLE_CYCLES; cap_valid rises on the next edge (edge t+STABLE_CYCLES, where t is the first edge sampling the value).
REQ-022 LOCKED: no further capture while the sample is unchanged; any change goes to COUNT (counter=1) or WAIT per REQ-018.
REQ-023 A legal capture SHALL write the nibble and clear digit_blank[i] in the same edge that asserts cap_valid.
REQ-024 A change sampled on the edge that would complete the count SHALL suppress that capture and restart counting.
REQ-025 Returning to a previously captured value after any different sample SHALL produce a new capture.
REQ-026 cap_valid, cap_err, cap_idx and cap_val SHALL be 0 in every cycle without a capture.

Reset
REQ-027 rst SHALL take priority over all other events, including a capture completing in the same cycle.
REQ-028 After a reset edge: state WAIT, counter 0, sample stage seg=1111111 and an=1111, digit_val=0, digit_blank=1111, cap_valid=cap_err=0, cap_idx=0, cap_val=0, sel_err=1.
REQ-029 Reset asserted mid-count SHALL discard the partial count; counting restarts from 0 after release.

Verification
REQ-030 Reset, then seg=0110000, an=1110 held from edge 1 with STABLE_CYCLES=4 -> one cap_valid pulse at edge 5, cap_idx=0, cap_val=3, digit_val=0x0003, digit_blank=1110; no further pulse while held.
REQ-031 seg=0001000, an=1011 held 3 samples, then seg=0000011 -> no capture for A; b captured 4 edges after its first sample; digit_val[11:8]=0xB.
REQ-032 seg=1010101, an=0111 held -> cap_valid=1 and cap_err=1 once, cap_val=0, digit_val and digit_blank unchanged.
REQ-033 an=1100 or an=1111 -> sel_err=1 from the next edge and no capture; an=1101 then -> capture at digit 1 after STABLE_CYCLES samples.
REQ-034 rst pulsed on the edge a capture would complete -> no cap_valid; all outputs at REQ-028 values; the same held input then captures STABLE_CYCLES+1 edges after rst is released.
